// File: rtl/tx_packet_arbiter.sv
// Round-robin arbiter that lets NUM_SRC byte-stream sources share one serial transmitter.
// A grant lasts for a whole packet, which ends on src_last, at the length limit, or on a stall timeout.
module tx_packet_arbiter #(
  parameter int NUM_SRC       = 4,
  parameter int MAX_PKT_LEN   = 16,
  parameter int GAP_CYCLES    = 2,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [NUM_SRC*8-1:0]       src_byte,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC-1:0]         src_last,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic [7:0]                 out_byte,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       busy,
  output logic [15:0]                packets_sent,
  output logic                       len_error,
  output logic                       timeout_error
);

  localparam int IDW = $clog2(NUM_SRC);
  localparam int CW  = $clog2(MAX_PKT_LEN) + 1;
  localparam int SW  = $clog2(STALL_TIMEOUT + 1);
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;
  localparam state_t END_ST = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t         state_q;
  logic [IDW-1:0] rr_ptr_q, grant_q;
  logic [CW-1:0]  byte_cnt_q;
  logic [SW-1:0]  stall_cnt_q;
  logic [GW-1:0]  gap_cnt_q;
  logic [15:0]    pkts_q;
  logic           len_err_q, to_err_q;
  logic [7:0]     out_byte_q;

  logic [7:0]     byte_arr [NUM_SRC];
  logic [7:0]     sel_byte;
  logic           sel_valid, sel_last, in_xfer, beat, found;
  logic [IDW-1:0] winner, cand, rr_next;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign byte_arr[gi]  = src_byte[8*gi +: 8];
      assign src_ready[gi] = in_xfer && out_ready && (grant_q == IDW'(gi));
    end
  endgenerate

  assign in_xfer   = (state_q == XFER);
  assign sel_byte  = byte_arr[grant_q];
  assign sel_valid = src_valid[grant_q];
  assign sel_last  = src_last[grant_q];
  assign beat      = in_xfer && sel_valid && out_ready;
  assign rr_next   = (grant_q == IDW'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;

  assign out_valid     = in_xfer && sel_valid;
  assign out_byte      = in_xfer ? sel_byte : out_byte_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != IDLE);
  assign packets_sent  = pkts_q;
  assign len_error     = len_err_q;
  assign timeout_error = to_err_q;

  // Search starts at rr_ptr and wraps; the first requesting source wins.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr_q;
    cand   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NUM_SRC);
      if (!found && src_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      byte_cnt_q  <= '0;
      stall_cnt_q <= '0;
      gap_cnt_q   <= '0;
      pkts_q      <= '0;
      len_err_q   <= 1'b0;
      to_err_q    <= 1'b0;
      out_byte_q  <= 8'h00;
    end else begin
      len_err_q <= 1'b0;
      to_err_q  <= 1'b0;
      if (in_xfer) out_byte_q <= sel_byte;
      case (state_q)
        IDLE: begin
          if (enable && found) begin
            grant_q     <= winner;
            byte_cnt_q  <= '0;
            stall_cnt_q <= '0;
            state_q     <= XFER;
          end
        end
        XFER: begin
          if (beat) begin
            byte_cnt_q  <= byte_cnt_q + 1'b1;
            stall_cnt_q <= '0;
            // src_last takes precedence so a full-length packet still counts as completed.
            if (sel_last) begin
              pkts_q    <= pkts_q + 16'd1;
              rr_ptr_q  <= rr_next;
              gap_cnt_q <= '0;
              state_q   <= END_ST;
            end else if (byte_cnt_q + 1'b1 == CW'(MAX_PKT_LEN)) begin
              len_err_q <= 1'b1;
              rr_ptr_q  <= rr_next;
              gap_cnt_q <= '0;
              state_q   <= END_ST;
            end
          end else if (sel_valid) begin
            stall_cnt_q <= '0;
          end else if (stall_cnt_q + 1'b1 == SW'(STALL_TIMEOUT)) begin
            to_err_q    <= 1'b1;
            stall_cnt_q <= '0;
            rr_ptr_q    <= rr_next;
            gap_cnt_q   <= '0;
            state_q     <= END_ST;
          end else begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_q <= IDLE;
          else gap_cnt_q <= gap_cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
